pacman_game_ctrl: RTL

Parametrised Pac-Man game-rule controller: once per video frame it compares Pac-Man's position against `NUM_GHOSTS` ghost positions and applies the collision rules. It also runs the power-pellet frightened timer, the lives counter, the death/respawn sequence and per-frame score increments. It sits between the sprite-motion logic (position sources) and the score/HUD logic (score and lives consumers).

---
 rtl/pacman_game_ctrl.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/pacman_game_ctrl.sv
// Pac-Man game-rule controller: per-frame collision, fright timer, lives, death/respawn and scoring.
// Build option: define PACMAN_GHOST_COMBO_EN for doubling ghost points (200/400/800/1600 saturating).
module pacman_game_ctrl #(
   parameter int NUM_GHOSTS    = 4,
   parameter int HIT_RADIUS    = 8,
   parameter int FRIGHT_FRAMES = 360,
   parameter int DEATH_FRAMES  = 120,
   parameter int LIVES_INIT    = 3
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     frame_tick,
   input  logic                     start,
   input  logic [9:0]               pacx,
   input  logic [8:0]               pacy,
   input  logic [10*NUM_GHOSTS-1:0] ghostx,
   input  logic [9*NUM_GHOSTS-1:0]  ghosty,
   input  logic                     pellet_eaten,
   input  logic                     power_eaten,
   output logic [1:0]               state,
   output logic [2:0]               lives,
   output logic                     frightened,
   output logic [NUM_GHOSTS-1:0]    ghost_eyes,
   output logic [NUM_GHOSTS-1:0]    ghost_eaten,
   output logic                     pac_dead,
   output logic                     respawn,
   output logic [13:0]              score_add
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_PLAY  = 2'd1,
      S_DYING = 2'd2,
      S_OVER  = 2'd3
   } state_t;

   state_t                st_q, st_d;
   logic [2:0]            lives_d;
   logic                  fr_d, dead_d, resp_d, die, load_fr;
   logic [9:0]            fcnt_q, fcnt_d;
   logic [7:0]            dcnt_q, dcnt_d;
   logic [NUM_GHOSTS-1:0] eyes_d, eaten_d, hit;
   logic [13:0]           score_d;
   logic [9:0]            gx, dx;
   logic [8:0]            gy, dy;
`ifdef PACMAN_GHOST_COMBO_EN
   logic [1:0]            combo_q, combo_d;
`endif

   assign state = st_q;

   // Unsigned absolute distance per ghost; eaten ghosts (eyes) never collide.
   always_comb begin
      hit = '0;
      gx  = '0;
      gy  = '0;
      dx  = '0;
      dy  = '0;
      for (int unsigned i = 0; i < NUM_GHOSTS; i++) begin
         gx = ghostx[10*i +: 10];
         gy = ghosty[9*i +: 9];
         dx = (pacx >= gx) ? pacx - gx : gx - pacx;
         dy = (pacy >= gy) ? pacy - gy : gy - pacy;
         hit[i] = (32'(dx) < HIT_RADIUS) && (32'(dy) < HIT_RADIUS) && !ghost_eyes[i];
      end
   end

   always_comb begin
      st_d    = st_q;
      lives_d = lives;
      fr_d    = frightened;
      fcnt_d  = fcnt_q;
      dcnt_d  = dcnt_q;
      eyes_d  = ghost_eyes;
      eaten_d = '0;
      dead_d  = 1'b0;
      resp_d  = 1'b0;
      score_d = '0;
      die     = 1'b0;
      load_fr = 1'b0;
`ifdef PACMAN_GHOST_COMBO_EN
      combo_d = combo_q;
`endif
      unique case (st_q)
         S_IDLE, S_OVER: begin
            if (start) begin
               st_d    = S_PLAY;
               lives_d = 3'(LIVES_INIT);
               fr_d    = 1'b0;
               fcnt_d  = '0;
               dcnt_d  = '0;
               eyes_d  = '0;
            end
         end
         S_PLAY: begin
            if (frame_tick) begin
               if (pellet_eaten) score_d = score_d + 14'd10;
               if (power_eaten)  score_d = score_d + 14'd50;
               // Ghost-vs-death decision uses the fright flag held before this tick.
               if (frightened) begin
                  for (int unsigned i = 0; i < NUM_GHOSTS; i++) begin
                     if (hit[i]) begin
                        eaten_d[i] = 1'b1;
                        eyes_d[i]  = 1'b1;
`ifdef PACMAN_GHOST_COMBO_EN
                        score_d = score_d + (14'd200 << combo_d);
                        if (combo_d != 2'd3) combo_d = combo_d + 2'd1;
`else
                        score_d = score_d + 14'd200;
`endif
                     end
                  end
               end else if (|hit) begin
                  die = 1'b1;
               end
               if (power_eaten) begin
                  load_fr = 1'b1;
                  fcnt_d  = 10'(FRIGHT_FRAMES);
                  fr_d    = 1'b1;
               end else if (fcnt_q != '0) begin
                  fcnt_d = fcnt_q - 10'd1;
                  if (fcnt_q == 10'd1) begin
                     fr_d   = 1'b0;
                     eyes_d = '0;
                  end
               end
               if (die) begin
                  dead_d  = 1'b1;
                  lives_d = lives - 3'd1;
                  st_d    = (lives == 3'd1) ? S_OVER : S_DYING;
                  dcnt_d  = 8'(DEATH_FRAMES);
                  fr_d    = 1'b0;
                  fcnt_d  = '0;
                  eyes_d  = '0;
               end
            end
         end
         S_DYING: begin
            if (frame_tick) begin
               dcnt_d = dcnt_q - 8'd1;
               if (dcnt_q == 8'd1) begin
                  resp_d = 1'b1;
                  st_d   = S_PLAY;
               end
            end
         end
         default: st_d = S_IDLE;
      endcase
`ifdef PACMAN_GHOST_COMBO_EN
      // Combo only lives within one fright period.
      if (load_fr || !fr_d) combo_d = '0;
`endif
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         st_q        <= S_IDLE;
         lives       <= '0;
         frightened  <= 1'b0;
         fcnt_q      <= '0;
         dcnt_q      <= '0;
         ghost_eyes  <= '0;
         ghost_eaten <= '0;
         pac_dead    <= 1'b0;
         respawn     <= 1'b0;
         score_add   <= '0;
      end else begin
         st_q        <= st_d;
         lives       <= lives_d;
         frightened  <= fr_d;
         fcnt_q      <= fcnt_d;
         dcnt_q      <= dcnt_d;
         ghost_eyes  <= eyes_d;
         ghost_eaten <= eaten_d;
         pac_dead    <= dead_d;
         respawn     <= resp_d;
         score_add   <= score_d;
      end
   end

`ifdef PACMAN_GHOST_COMBO_EN
   always_ff @(posedge clk) begin
      if (rst) combo_q <= '0;
      else     combo_q <= combo_d;
   end
`endif

endmodule
